i2c_slave_mem: RTL
==================

# i2c_slave_mem

Parametrised I2C target bridging an external I2C bus to an on-chip byte-wide memory, with both read and write access. It answers a configurable 7-bit device address and receives a 1–4 byte memory pointer. It then streams sequential reads from, or writes to, the memory port, auto-incrementing the pointer. It sits between the board-level SCL/SDA pins (open-drain, external pull-up) and a synchronous memory or register file in the in_clk domain.

## Interface
- DEV_ADDR, 7'h50: 7-bit I2C device address answered.
- MEM_ADDR_WIDTH, 16: memory pointer width, 1..32.
- ADDR_BYTES, 2: pointer bytes sent by the master after a write header, 1..4; MSB first; bits above MEM_ADDR_WIDTH are discarded.
- SDA_SETUP_DELAY_CYCLES, 3: in_clk cycles between the internal SCL falling edge and a change of SDA drive; must be ≥1.
- in_clk  input  1  system clock; must be ≥ 16× SCL.
- in_rst_n  input  1  asynchronous active-low reset.
- in_scl  input  1  I2C clock; sampled only.
- io_sda  inout  1  I2C data; driven 0 or released to z, never driven 1.
- out_sda_oe  output  1  high while the block pulls SDA low; reset 0.
- out_mem_addr  output  MEM_ADDR_WIDTH  current memory pointer; reset 0.
- out_mem_wdata  output  8  write data, valid with out_mem_we; reset 0.
- out_mem_we  output  1  one-cycle write strobe; reset 0.
- in_mem_rdata  input  8  read data for out_mem_addr; must be valid 2 in_clk cycles after out_mem_addr changes.

## Operation
- SCL and SDA pass through 2-flop synchronisers and are then edge-detected on the synchronised values.
- START or repeated START: SDA falls while SCL is high. It is accepted in any state and moves the block to DEV_ADDR with the bit counter cleared and SDA released.
- STOP: SDA rises while SCL is high. It moves the block to IDLE from any state and releases SDA. The pointer is retained.
- Bits are sampled on SCL rising edges, MSB first. SDA drive changes only after SCL falling edges.
- States and transitions:
  - IDLE: wait for START.
  - DEV_ADDR: 8 bits received. If the top 7 bits equal DEV_ADDR, go to ACK and latch R/W from bit 0. On mismatch, go to WAIT_STOP with no ACK driven.
  - ACK: drive SDA low for one SCL bit.
    - After a write header, go to RX_BYTE and clear the pointer-byte counter.
    - After a read header, go to TX_BYTE.
    - After a received byte, go to RX_BYTE.
  - RX_BYTE: 8 bits received.
    - While the pointer-byte counter is below ADDR_BYTES, shift the byte into the pointer and increment the counter.
    - Otherwise, write the byte: set out_mem_wdata to it and pulse out_mem_we for one cycle at the current out_mem_addr. The pointer increments on the following cycle.
    - Then go to ACK.
  - TX_BYTE: on entry, load in_mem_rdata into the shift register and increment the pointer. Shift 8 bits out; a 0 bit drives SDA low, a 1 bit releases it. Then go to WAIT_MACK.
  - WAIT_MACK: SDA released; sample one bit. If the master ACKs (0), go to TX_BYTE. If it NACKs (1), go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- The pointer wraps from 2^MEM_ADDR_WIDTH−1 to 0.
- A write header followed by a repeated START and a read header reads from the pointer just loaded.

## Timing
- SDA release or assert takes effect SDA_SETUP_DELAY_CYCLES in_clk cycles after the synchronised SCL falling edge.
- The ACK bit is asserted after the falling edge that ends bit 8 and released after the falling edge that ends the ACK bit.
- For TX_BYTE, in_mem_rdata is sampled at the synchronised SCL falling edge that ends the ACK or master-ACK bit. The pointer increments 1 cycle after that sample.
- out_mem_we pulses 1 cycle after the 8th rising edge of a data byte.
- out_sda_oe is never asserted while SCL is synchronised high, except across the hold of a driven bit.
- A START/STOP that arrives on the same cycle as an SCL edge takes priority over the bit logic.
- Asserting in_rst_n low mid-transfer releases SDA immediately (asynchronously) and resets every output to its reset value.

## Test plan
- Write then read back: START, 0xA0, 0x12, 0x34, 0xAB, 0xCD, STOP. Expect 5 ACKs; we pulses at addresses 0x1234 (data 0xAB) and 0x1235 (data 0xCD); final pointer 0x1236.
- Random read: START, 0xA0, 0x12, 0x34, repeated START, 0xA1. The master ACKs 2 bytes and NACKs the 3rd, then STOP. Expect the bytes at 0x1234, 0x1235 and 0x1236 on SDA, and a final pointer of 0x1237.
- Address mismatch: START, 0xA2, then 8 more bytes, then STOP. Expect SDA never driven and no we pulses.
- Wraparound with MEM_ADDR_WIDTH=8, ADDR_BYTES=1: write pointer 0xFF, then 2 data bytes. Expect writes at 0xFF then 0x00.
- Abort: STOP in the middle of the 4th bit of a data byte. Expect IDLE, SDA released, no we. A following START and 0xA1 reads at the unchanged pointer.
- Reset mid-ACK: pull in_rst_n low while out_sda_oe=1. Expect out_sda_oe=0 in the same cycle, out_mem_addr=0, and the block ignores the bus until the next START.

Source files
------------

// File: rtl/i2c_slave_mem.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_slave_mem
//
// I2C target that bridges an external I2C bus to a byte-wide synchronous
// memory. After a matching write header the master sends ADDR_BYTES pointer
// bytes (MSB first), followed by optional data bytes that are written at the
// auto-incrementing pointer. After a matching read header, bytes are streamed
// out from the pointer, which also auto-increments.
//
// Ports:
//   in_clk         system clock (at least 16x SCL)
//   in_rst_n       asynchronous active-low reset
//   in_scl         I2C clock, sampled only
//   io_sda         I2C data, open drain (driven 0 or released)
//   out_sda_oe     high while this block pulls SDA low
//   out_mem_addr   current memory pointer
//   out_mem_wdata  write data, valid with out_mem_we
//   out_mem_we     one-cycle write strobe
//   in_mem_rdata   read data for out_mem_addr (valid 2 cycles after a change)
// ---------------------------------------------------------------------------
module i2c_slave_mem #(
    parameter logic [6:0] DEV_ADDR               = 7'h50,
    parameter int         MEM_ADDR_WIDTH         = 16,
    parameter int         ADDR_BYTES             = 2,
    parameter int         SDA_SETUP_DELAY_CYCLES = 3
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_scl,
    inout  wire                       io_sda,
    output logic                      out_sda_oe,
    output logic [MEM_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [7:0]                out_mem_wdata,
    output logic                      out_mem_we,
    input  logic [7:0]                in_mem_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DEV_ADDR  = 3'd1;
    localparam logic [2:0] S_ACK       = 3'd2;
    localparam logic [2:0] S_RX_BYTE   = 3'd3;
    localparam logic [2:0] S_TX_BYTE   = 3'd4;
    localparam logic [2:0] S_WAIT_MACK = 3'd5;
    localparam logic [2:0] S_WAIT_STOP = 3'd6;

    localparam int           DW         = $clog2(SDA_SETUP_DELAY_CYCLES + 1);
    localparam logic [DW-1:0] DLY       = DW'(SDA_SETUP_DELAY_CYCLES);
    localparam logic [2:0]   PTR_BYTES  = 3'(ADDR_BYTES);

    // Open-drain output: never drive a 1.
    assign io_sda = out_sda_oe ? 1'b0 : 1'bz;

    logic          scl_meta, scl_sync, scl_prev;
    logic          sda_meta, sda_sync, sda_prev;
    logic [2:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          ack_to_tx;     // what follows the ACK bit: 1 = transmit, 0 = receive
    logic          ack_on;        // ACK drive already scheduled in this ACK slot
    logic          mack_seen;     // master ACKed, load next byte on the coming fall
    logic [2:0]    ptr_cnt;
    logic          inc_pending;
    logic [DW-1:0] delay_cnt;
    logic          pend_oe;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    // SCL must be high on both samples so an SCL edge never looks like START/STOP.
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;
    assign rx_byte   = {shift[6:0], sda_sync};

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            // Synchronisers reset to the idle bus level to avoid false edges.
            scl_meta      <= 1'b1;
            scl_sync      <= 1'b1;
            scl_prev      <= 1'b1;
            sda_meta      <= 1'b1;
            sda_sync      <= 1'b1;
            sda_prev      <= 1'b1;
            state         <= S_IDLE;
            bit_cnt       <= 4'd0;
            shift         <= 8'd0;
            ack_to_tx     <= 1'b0;
            ack_on        <= 1'b0;
            mack_seen     <= 1'b0;
            ptr_cnt       <= 3'd0;
            inc_pending   <= 1'b0;
            delay_cnt     <= '0;
            pend_oe       <= 1'b0;
            out_sda_oe    <= 1'b0;
            out_mem_addr  <= '0;
            out_mem_wdata <= 8'd0;
            out_mem_we    <= 1'b0;
        end else begin
            scl_meta   <= in_scl;
            scl_sync   <= scl_meta;
            scl_prev   <= scl_sync;
            sda_meta   <= io_sda;
            sda_sync   <= sda_meta;
            sda_prev   <= sda_sync;
            out_mem_we <= 1'b0;

            // Pointer increment one cycle after a write strobe or a read load.
            if (inc_pending) begin
                out_mem_addr <= out_mem_addr + 1'b1;
                inc_pending  <= 1'b0;
            end

            // SDA drive changes are scheduled at an SCL fall and applied later,
            // giving hold time after the fall and setup before the next rise.
            if (delay_cnt != '0) begin
                delay_cnt <= delay_cnt - DW'(1);
                if (delay_cnt == DW'(1)) begin
                    out_sda_oe <= pend_oe;
                end
            end

            if (start_det || stop_det) begin
                state      <= start_det ? S_DEV_ADDR : S_IDLE;
                bit_cnt    <= 4'd0;
                out_sda_oe <= 1'b0;
                delay_cnt  <= '0;
                ack_on     <= 1'b0;
                mack_seen  <= 1'b0;
            end else begin
                case (state)
                    S_DEV_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                if (shift[6:0] == DEV_ADDR) begin
                                    state     <= S_ACK;
                                    ack_to_tx <= sda_sync;
                                    ack_on    <= 1'b0;
                                    ptr_cnt   <= 3'd0;
                                end else begin
                                    state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end

                    S_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                // Fall ending bit 8: pull SDA low for the ACK bit.
                                ack_on    <= 1'b1;
                                pend_oe   <= 1'b1;
                                delay_cnt <= DLY;
                            end else begin
                                // Fall ending the ACK bit.
                                ack_on    <= 1'b0;
                                bit_cnt   <= 4'd0;
                                delay_cnt <= DLY;
                                if (ack_to_tx) begin
                                    shift       <= in_mem_rdata;
                                    inc_pending <= 1'b1;
                                    pend_oe     <= ~in_mem_rdata[7];
                                    state       <= S_TX_BYTE;
                                end else begin
                                    pend_oe <= 1'b0;
                                    state   <= S_RX_BYTE;
                                end
                            end
                        end
                    end

                    S_RX_BYTE: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= 4'd0;
                                state     <= S_ACK;
                                ack_to_tx <= 1'b0;
                                ack_on    <= 1'b0;
                                if (ptr_cnt < PTR_BYTES) begin
                                    // Bits shifted above the pointer width fall off.
                                    out_mem_addr <= MEM_ADDR_WIDTH'({out_mem_addr, rx_byte});
                                    ptr_cnt      <= ptr_cnt + 3'd1;
                                end else begin
                                    out_mem_wdata <= rx_byte;
                                    out_mem_we    <= 1'b1;
                                    inc_pending   <= 1'b1;
                                end
                            end
                        end
                    end

                    S_TX_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            delay_cnt <= DLY;
                            if (bit_cnt == 4'd8) begin
                                pend_oe   <= 1'b0;
                                bit_cnt   <= 4'd0;
                                mack_seen <= 1'b0;
                                state     <= S_WAIT_MACK;
                            end else begin
                                // Rotate so the next bit to send sits in shift[7].
                                shift   <= {shift[6:0], shift[7]};
                                pend_oe <= ~shift[6];
                            end
                        end
                    end

                    S_WAIT_MACK: begin
                        if (scl_rise) begin
                            if (sda_sync) begin
                                state <= S_WAIT_STOP;
                            end else begin
                                mack_seen <= 1'b1;
                            end
                        end else if (scl_fall && mack_seen) begin
                            mack_seen   <= 1'b0;
                            bit_cnt     <= 4'd0;
                            shift       <= in_mem_rdata;
                            inc_pending <= 1'b1;
                            pend_oe     <= ~in_mem_rdata[7];
                            delay_cnt   <= DLY;
                            state       <= S_TX_BYTE;
                        end
                    end

                    default: begin
                        // IDLE and WAIT_STOP only react to START/STOP.
                    end
                endcase
            end
        end
    end

endmodule
